// File: rtl/resistors_readback_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : resistors_readback_encoder                                       |
// | Desc    : Re-encodes the serial R_ctr readback word to the 4-bit r_prog    |
// |           code, confirms it over CONFIRM_N frames, flags errors/timeouts.  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module resistors_readback_encoder #(
  parameter int CONFIRM_N = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       bit_vld,
  input  logic       bit_in,
  output logic [3:0] r_prog,
  output logic       r_prog_vld,
  output logic       upd,
  output logic       code_err,
  output logic       tmo_err,
  output logic       busy
);

  localparam int GW = $clog2(TIMEOUT + 1);
  localparam int MW = $clog2(CONFIRM_N + 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_MAX    = {GW{1'b1}};
  localparam logic [MW-1:0] MATCH_FULL = MW'(CONFIRM_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_shreg, w_shreg_nxt;
  logic [3:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic [GW-1:0]   r_gap, w_gap_nxt;
  logic            w_tmo;
  logic [3:0]      r_cand, w_cand_nxt;
  logic [MW-1:0]   r_match, w_match_nxt;
  logic [2:0]      w_hi, w_lo;
  logic            w_legal, w_load;
  logic [3:0]      w_code;

  // Returns {legal, value} for one R_ctr nibble.
  function automatic logic [2:0] dec_nib(input logic [3:0] n);
    case (n)
      4'b1110: dec_nib = 3'b100;
      4'b0101: dec_nib = 3'b101;
      4'b1101: dec_nib = 3'b110;
      4'b1011: dec_nib = 3'b111;
      default: dec_nib = 3'b000;
    endcase
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_nxt     = r_gap;
    w_tmo         = 1'b0;
    case (r_state)
      SHIFT: begin
        if (bit_vld) begin
          w_shreg_nxt   = {r_shreg[6:0], bit_in};
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          w_gap_nxt     = '0;
          if (r_bit_cnt == 4'd7) w_state_nxt = CHECK;
        end else if (r_gap == GAP_LAST) begin
          w_tmo       = 1'b1;
          w_gap_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (r_gap != GAP_MAX) begin
          w_gap_nxt = r_gap + GW'(1);
        end
      end
      CHECK:   w_state_nxt = IDLE;
      default: w_state_nxt = r_state;
    endcase
    // A new frame overrides everything, including a pending timeout.
    if (frame_start) begin
      w_state_nxt   = SHIFT;
      w_gap_nxt     = '0;
      w_tmo         = 1'b0;
      w_bit_cnt_nxt = bit_vld ? 4'd1 : 4'd0;
      if (bit_vld) w_shreg_nxt = {r_shreg[6:0], bit_in};
    end
  end

  always_comb begin
    w_hi    = dec_nib(r_shreg[7:4]);
    w_lo    = dec_nib(r_shreg[3:0]);
    w_legal = w_hi[2] & w_lo[2];
    w_code  = {w_lo[1:0], w_hi[1:0]};
    if (w_code == r_cand) begin
      w_cand_nxt  = r_cand;
      w_match_nxt = (r_match == MATCH_FULL) ? r_match : r_match + MW'(1);
    end else begin
      w_cand_nxt  = w_code;
      w_match_nxt = MW'(1);
    end
    w_load = (w_match_nxt == MATCH_FULL) && (!r_prog_vld || (w_code != r_prog));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_gap      <= '0;
      r_cand     <= '0;
      r_match    <= '0;
      r_prog     <= '0;
      r_prog_vld <= 1'b0;
      upd        <= 1'b0;
      code_err   <= 1'b0;
      tmo_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap     <= w_gap_nxt;
      busy      <= (w_state_nxt != IDLE);
      upd       <= 1'b0;
      code_err  <= 1'b0;
      tmo_err   <= w_tmo;
      if (w_tmo) r_match <= '0;
      if (r_state == CHECK) begin
        if (!w_legal) begin
          code_err <= 1'b1;
          r_match  <= '0;
        end else begin
          r_cand  <= w_cand_nxt;
          r_match <= w_match_nxt;
          if (w_load) begin
            r_prog     <= w_code;
            r_prog_vld <= 1'b1;
            upd        <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_resistors_readback_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_resistors_readback_encoder                                    |
// | Desc    : Directed self-checking bench for resistors_readback_encoder.     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_resistors_readback_encoder;

  localparam int CONFIRM_N = 2;
  localparam int TIMEOUT   = 16;

  logic       clk = 1'b0;
  logic       rst_n, frame_start, bit_vld, bit_in;
  logic [3:0] r_prog;
  logic       r_prog_vld, upd, code_err, tmo_err, busy;

  int total = 0;
  int bad   = 0;

  resistors_readback_encoder #(.CONFIRM_N(CONFIRM_N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_vld(bit_vld),
    .bit_in(bit_in), .r_prog(r_prog), .r_prog_vld(r_prog_vld), .upd(upd),
    .code_err(code_err), .tmo_err(tmo_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bit_vld = 1'b1;
      bit_in  = w[7-i];
      step();
    end
    bit_vld = 1'b0;
    bit_in  = 1'b0;
  endtask

  // Full frame; returns one cycle after the CHECK state so results are visible.
  task automatic frame(input logic [7:0] w);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    send_bits(w, 8);
    step();
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; bit_vld = 1'b0; bit_in = 1'b0;

    // 1: reset and IDLE behaviour
    repeat (3) step();
    chk("rst_r_prog", {4'h0, r_prog}, 8'h00);
    chk("rst_flags", {3'b0, r_prog_vld, upd, code_err, tmo_err, busy}, 8'h00);
    rst_n = 1'b1;
    bit_vld = 1'b1; bit_in = 1'b1;
    repeat (4) step();
    bit_vld = 1'b0;
    step();
    chk("idle_ignore", {3'b0, r_prog_vld, upd, code_err, tmo_err, busy}, 8'h00);

    // 2: confirmation of 0x5E -> 1
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("busy_shift", {7'b0, busy}, 8'h01);
    send_bits(8'h5E, 8);
    step();
    chk("f1_upd", {7'b0, upd}, 8'h00);
    chk("f1_vld", {7'b0, r_prog_vld}, 8'h00);
    chk("f1_busy", {7'b0, busy}, 8'h00);
    frame(8'h5E);
    chk("f2_upd", {7'b0, upd}, 8'h01);
    chk("f2_r_prog", {4'h0, r_prog}, 8'h01);
    chk("f2_vld", {7'b0, r_prog_vld}, 8'h01);
    step();
    chk("upd_pulse", {7'b0, upd}, 8'h00);
    frame(8'h5E);
    chk("f3_same_upd", {7'b0, upd}, 8'h00);

    // 3: alternating candidates, single update at the end
    frame(8'hBB);
    chk("t3a_upd", {7'b0, upd}, 8'h00);
    frame(8'h5E);
    chk("t3b_upd", {7'b0, upd}, 8'h00);
    frame(8'hBB);
    chk("t3c_upd", {7'b0, upd}, 8'h00);
    frame(8'hBB);
    chk("t3d_upd", {7'b0, upd}, 8'h01);
    chk("t3d_r_prog", {4'h0, r_prog}, 8'h0F);

    // 4: illegal words clear the match count
    frame(8'h5E);
    chk("t4_prime_upd", {7'b0, upd}, 8'h00);
    frame(8'hFF);
    chk("t4_ff_err", {7'b0, code_err}, 8'h01);
    chk("t4_ff_r_prog", {4'h0, r_prog}, 8'h0F);
    chk("t4_ff_upd", {7'b0, upd}, 8'h00);
    step();
    chk("t4_err_pulse", {7'b0, code_err}, 8'h00);
    frame(8'hE7);
    chk("t4_e7_err", {7'b0, code_err}, 8'h01);
    chk("t4_e7_r_prog", {4'h0, r_prog}, 8'h0F);
    frame(8'h5E);
    chk("t4_cleared_upd", {7'b0, upd}, 8'h00);
    chk("t4_legal_noerr", {7'b0, code_err}, 8'h00);
    frame(8'h5E);
    chk("t4_final_upd", {7'b0, upd}, 8'h01);
    chk("t4_final_r_prog", {4'h0, r_prog}, 8'h01);

    // 5: timeout, then restart mid-frame
    frame_start = 1'b1; step(); frame_start = 1'b0;
    send_bits(8'hA0, 3);
    repeat (TIMEOUT - 1) step();
    chk("t5_pre_tmo", {6'b0, tmo_err, busy}, 8'h01);
    step();
    chk("t5_tmo", {5'b0, tmo_err, busy, upd}, 8'h04);
    step();
    chk("t5_tmo_pulse", {7'b0, tmo_err}, 8'h00);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    send_bits(8'h5E, 5);
    frame(8'hEE);
    chk("t5_restart", {6'b0, code_err, upd}, 8'h00);
    frame(8'hEE);
    chk("t5_ee_upd", {7'b0, upd}, 8'h01);
    chk("t5_ee_r_prog", {4'h0, r_prog}, 8'h00);

    // 6: reset mid-frame
    frame_start = 1'b1; step(); frame_start = 1'b0;
    send_bits(8'hBB, 6);
    rst_n = 1'b0; bit_vld = 1'b1; bit_in = 1'b1;
    step();
    rst_n = 1'b1; bit_vld = 1'b0;
    chk("t6_rst_r_prog", {4'h0, r_prog}, 8'h00);
    chk("t6_rst_flags", {3'b0, r_prog_vld, upd, code_err, tmo_err, busy}, 8'h00);
    frame(8'hBB);
    chk("t6_f1_upd", {7'b0, upd}, 8'h00);
    frame(8'hBB);
    chk("t6_f2_upd", {7'b0, upd}, 8'h01);
    chk("t6_f2_r_prog", {4'h0, r_prog}, 8'h0F);
    chk("t6_f2_vld", {7'b0, r_prog_vld}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
